reorder_buffer_mc: RTL and testbench

Parametrised in-order retirement buffer for the out-of-order RV32I core. It replaces the single-commit ROB with:
- configurable depth;
- N writeback channels from the RS/ALU/LSB units;
- up to two retirements per cycle;
- an exact occupancy counter;
- full-PC branch verification with a registered flush.

It sits between the decoder (allocation), the execution units (writeback), the register file (commit, dependency query) and the LSB (store release).

---
 rtl/reorder_buffer_mc.sv | 179 +++++++++++++++++
 tb/tb_reorder_buffer_mc.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_mc.sv
// In-order retirement buffer: multi-port writeback with operand bypass, dual commit,
// branch verification against the full predicted PC with a registered one-cycle flush.
module reorder_buffer_mc #(
  parameter int DEPTH_BIT    = 4,
  parameter int WB_PORTS     = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             alloc_valid,
  input  logic [1:0]                       alloc_type,
  input  logic [4:0]                       alloc_rd,
  input  logic                             alloc_ready,
  input  logic [31:0]                      alloc_value,
  input  logic [31:0]                      alloc_pred_pc,
  output logic [DEPTH_BIT-1:0]             alloc_id,
  input  logic [WB_PORTS-1:0]              wb_valid,
  input  logic [WB_PORTS*DEPTH_BIT-1:0]    wb_id,
  input  logic [WB_PORTS*32-1:0]           wb_value,
  input  logic [2*DEPTH_BIT-1:0]           q_id,
  output logic [1:0]                       q_ready,
  output logic [63:0]                      q_value,
  output logic                             full,
  output logic                             empty,
  output logic [DEPTH_BIT:0]               count,
  output logic [DEPTH_BIT-1:0]             head_id,
  output logic [COMMIT_WIDTH-1:0]          commit_valid,
  output logic [5*COMMIT_WIDTH-1:0]        commit_rd,
  output logic [DEPTH_BIT*COMMIT_WIDTH-1:0] commit_id,
  output logic [32*COMMIT_WIDTH-1:0]       commit_value,
  output logic                             store_commit,
  output logic                             flush,
  output logic [31:0]                      flush_pc,
  output logic                             halt
);
  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam int CW    = DEPTH_BIT + 1;

  typedef enum logic [1:0] {T_RG = 2'd0, T_ST = 2'd1, T_BR = 2'd2, T_EX = 2'd3} rob_type_e;

  logic [DEPTH_BIT-1:0] head, tail, head1;
  logic [DEPTH-1:0]     busy, ready;
  rob_type_e            typ     [DEPTH];
  logic [4:0]           rd_q    [DEPTH];
  logic [31:0]          value_q [DEPTH];
  logic [31:0]          pred_q  [DEPTH];

  logic [DEPTH_BIT-1:0] wbid  [WB_PORTS];
  logic [31:0]          wbval [WB_PORTS];
  logic [WB_PORTS-1:0]  wb_hit;
  logic                 alloc_fire, c0, c1, mispredict, plain0, plain1;
  logic [1:0]           n_commit;
  logic [DEPTH_BIT-1:0] sid  [2];
  logic [1:0]           fire;
  logic [DEPTH_BIT-1:0] qi;
  logic                 qhit;
  logic [31:0]          qhv;

  always_comb begin
    for (int k = 0; k < WB_PORTS; k++) begin
      wbid[k]   = wb_id[k*DEPTH_BIT +: DEPTH_BIT];
      wbval[k]  = wb_value[k*32 +: 32];
      wb_hit[k] = wb_valid[k] && busy[wbid[k]];
    end
  end

  assign head1      = head + DEPTH_BIT'(1);
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign alloc_id   = tail;
  assign head_id    = head;
  assign alloc_fire = rdy_in && alloc_valid && !full && !flush && !halt;
  assign plain0     = (typ[head] == T_RG) || (typ[head] == T_ST);
  assign plain1     = (typ[head1] == T_RG) || (typ[head1] == T_ST);
  assign c0         = rdy_in && !flush && !halt && busy[head] && ready[head];
  // Branches and EX retire alone so the flush/halt decision only ever looks at slot 0.
  assign c1 = (COMMIT_WIDTH > 1) && c0 && busy[head1] && ready[head1] && plain0 && plain1 &&
              !((typ[head] == T_ST) && (typ[head1] == T_ST));
  assign n_commit   = {1'b0, c0} + {1'b0, c1};
  assign mispredict = c0 && (typ[head] == T_BR) && (value_q[head] != pred_q[head]);
  assign store_commit = (c0 && typ[head] == T_ST) || (c1 && typ[head1] == T_ST);

  always_comb begin
    sid[0]       = head;
    sid[1]       = head1;
    fire         = {c1, c0};
    commit_valid = '0;
    commit_rd    = '0;
    commit_id    = '0;
    commit_value = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_valid[k]                    = fire[k];
      commit_id[k*DEPTH_BIT +: DEPTH_BIT] = sid[k];
      commit_rd[k*5 +: 5]                = (typ[sid[k]] == T_RG) ? rd_q[sid[k]] : 5'd0;
      commit_value[k*32 +: 32]           = value_q[sid[k]];
    end
  end

  always_comb begin
    q_ready = '0;
    q_value = '0;
    qi      = '0;
    qhit    = 1'b0;
    qhv     = '0;
    for (int j = 0; j < 2; j++) begin
      qi   = q_id[j*DEPTH_BIT +: DEPTH_BIT];
      qhit = 1'b0;
      qhv  = '0;
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_hit[k] && (wbid[k] == qi)) begin
          qhit = 1'b1;
          qhv  = wbval[k];
        end
      end
      q_ready[j]         = ready[qi] || qhit;
      q_value[j*32 +: 32] = ready[qi] ? value_q[qi] : (qhit ? qhv : 32'd0);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      busy     <= '0;
      ready    <= '0;
      flush    <= 1'b0;
      flush_pc <= '0;
      halt     <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
      flush <= 1'b0;
    end else if (rdy_in) begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_hit[k]) ready[wbid[k]] <= 1'b1;
      end
      if (c0) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
      end
      if (c1) begin
        busy[head1]  <= 1'b0;
        ready[head1] <= 1'b0;
      end
      if (alloc_fire) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= alloc_ready;
      end
      head  <= head + DEPTH_BIT'(n_commit);
      tail  <= tail + DEPTH_BIT'(alloc_fire);
      count <= count + CW'(alloc_fire) - CW'(n_commit);
      if (mispredict) begin
        flush    <= 1'b1;
        flush_pc <= value_q[head];
      end
      if (c0 && typ[head] == T_EX) halt <= 1'b1;
    end
  end

  // Payload needs no reset: busy/ready gate every observable use of it.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush) begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_hit[k]) value_q[wbid[k]] <= wbval[k];
      end
      if (alloc_fire) begin
        typ[tail]     <= rob_type_e'(alloc_type);
        rd_q[tail]    <= alloc_rd;
        value_q[tail] <= alloc_value;
        pred_q[tail]  <= alloc_pred_pc;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Bench for reorder_buffer_mc: vector table, directed corner sequences and a random
// run against a queue-based model of program-order entries.
module tb_reorder_buffer_mc;
  localparam int DB = 4, WB = 2, CWD = 2, DEPTH = 16;

  logic clk_in, rst_in, rdy_in, alloc_valid, alloc_ready;
  logic [1:0] alloc_type;
  logic [4:0] alloc_rd;
  logic [31:0] alloc_value, alloc_pred_pc;
  logic [DB-1:0] alloc_id, head_id;
  logic [WB-1:0] wb_valid;
  logic [WB*DB-1:0] wb_id;
  logic [WB*32-1:0] wb_value;
  logic [2*DB-1:0] q_id;
  logic [1:0] q_ready;
  logic [63:0] q_value;
  logic full, empty, store_commit, flush, halt;
  logic [DB:0] count;
  logic [CWD-1:0] commit_valid;
  logic [5*CWD-1:0] commit_rd;
  logic [DB*CWD-1:0] commit_id;
  logic [32*CWD-1:0] commit_value;
  logic [31:0] flush_pc;

  reorder_buffer_mc #(.DEPTH_BIT(DB), .WB_PORTS(WB), .COMMIT_WIDTH(CWD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_value(alloc_value), .alloc_pred_pc(alloc_pred_pc),
    .alloc_id(alloc_id), .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .q_id(q_id), .q_ready(q_ready), .q_value(q_value), .full(full), .empty(empty),
    .count(count), .head_id(head_id), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_id(commit_id), .commit_value(commit_value), .store_commit(store_commit),
    .flush(flush), .flush_pc(flush_pc), .halt(halt));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  typedef struct {
    int id; bit rdy; bit [1:0] typ; bit [4:0] rd; bit [31:0] val; bit [31:0] pred;
  } ent_t;
  ent_t mq[$];
  int m_tail;
  bit m_flush, m_halt;
  bit [31:0] m_flush_pc;

  typedef struct {
    logic [1:0] typ; logic [4:0] rd; logic rdy; logic [31:0] val; logic [31:0] pred;
    logic ecv; logic [4:0] erd; logic est; logic efl;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; alloc_valid = 1'b0; alloc_type = 2'd0; alloc_rd = 5'd0;
    alloc_ready = 1'b0; alloc_value = '0; alloc_pred_pc = '0;
    wb_valid = '0; wb_id = '0; wb_value = '0; q_id = '0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    mq.delete(); m_tail = 0; m_flush = 0; m_halt = 0; m_flush_pc = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b0;
    #2;
    tick();
    rst_in = 1'b1;
    model_reset();
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] r, input logic rdy,
                       input logic [31:0] v, input logic [31:0] p);
    alloc_valid = 1'b1; alloc_type = t; alloc_rd = r; alloc_ready = rdy;
    alloc_value = v; alloc_pred_pc = p;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_alloc_id"}, alloc_id, 0);
    chk({tag, "_head_id"}, head_id, 0);
    chk({tag, "_commit_valid"}, commit_valid, 0);
    chk({tag, "_store_commit"}, store_commit, 0);
    chk({tag, "_q_ready"}, q_ready, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_halt"}, halt, 0);
  endtask

  function automatic int find(input int id);
    for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
    return -1;
  endfunction

  function automatic logic [DB-1:0] pick_id();
    if (mq.size() > 0 && ($urandom % 4) != 0) return DB'(mq[$urandom % mq.size()].id);
    return DB'($urandom % DEPTH);
  endfunction

  task automatic rand_cycle();
    int n, idx, r;
    bit e0, e1, er, hit, h0;
    bit [1:0] t0;
    bit [31:0] v0, p0, ev;
    ent_t e;
    rdy_in = ($urandom % 8) != 0;
    alloc_valid = ($urandom % 4) != 0;
    r = $urandom % 256;
    alloc_type = (r == 0) ? 2'd3 : (r < 32) ? 2'd2 : (r < 96) ? 2'd1 : 2'd0;
    alloc_rd = 5'($urandom);
    alloc_ready = ($urandom % 3) == 0;
    alloc_value = $urandom_range(0, 3);
    alloc_pred_pc = $urandom_range(0, 3);
    for (int k = 0; k < WB; k++) begin
      wb_valid[k] = 1'($urandom % 2);
      wb_id[k*DB +: DB] = pick_id();
      wb_value[k*32 +: 32] = (($urandom % 2) != 0) ? $urandom_range(0, 3) : $urandom;
    end
    for (int j = 0; j < 2; j++) q_id[j*DB +: DB] = pick_id();
    #1;
    n = mq.size();
    e0 = 0; e1 = 0; t0 = 0; v0 = 0; p0 = 0;
    if (n > 0) begin
      t0 = mq[0].typ; v0 = mq[0].val; p0 = mq[0].pred;
      e0 = mq[0].rdy && rdy_in && !m_flush && !m_halt;
    end
    if (n > 1 && e0)
      e1 = mq[1].rdy && mq[0].typ < 2 && mq[1].typ < 2 && !(mq[0].typ == 1 && mq[1].typ == 1);
    chk("r_alloc_id", alloc_id, m_tail);
    chk("r_count", count, n);
    chk("r_full", full, n == DEPTH);
    chk("r_empty", empty, n == 0);
    chk("r_head_id", head_id, (n > 0) ? mq[0].id : m_tail);
    chk("r_commit_valid", commit_valid, {e1, e0});
    if (e0) begin
      chk("r_commit_rd0", commit_rd[4:0], (mq[0].typ == 0) ? mq[0].rd : 0);
      chk("r_commit_id0", commit_id[DB-1:0], mq[0].id);
      chk("r_commit_value0", commit_value[31:0], mq[0].val);
    end
    if (e1) begin
      chk("r_commit_rd1", commit_rd[9:5], (mq[1].typ == 0) ? mq[1].rd : 0);
      chk("r_commit_id1", commit_id[2*DB-1:DB], mq[1].id);
      chk("r_commit_value1", commit_value[63:32], mq[1].val);
    end
    chk("r_store_commit", store_commit, (e0 && mq[0].typ == 1) || (e1 && mq[1].typ == 1));
    chk("r_flush", flush, m_flush);
    if (m_flush) chk("r_flush_pc", flush_pc, m_flush_pc);
    chk("r_halt", halt, m_halt);
    for (int j = 0; j < 2; j++) begin
      idx = find(int'(q_id[j*DB +: DB]));
      er = 0; ev = 0; hit = 0;
      if (idx >= 0 && mq[idx].rdy) begin
        er = 1; ev = mq[idx].val;
      end else if (idx >= 0) begin
        for (int k = 0; k < WB; k++)
          if (wb_valid[k] && wb_id[k*DB +: DB] == q_id[j*DB +: DB]) begin
            hit = 1; ev = wb_value[k*32 +: 32];
          end
        er = hit;
      end
      chk($sformatf("r_q_ready%0d", j), q_ready[j], er);
      chk($sformatf("r_q_value%0d", j), q_value[j*32 +: 32], ev);
    end
    if (m_flush) begin
      mq.delete(); m_tail = 0; m_flush = 0;
    end else if (rdy_in) begin
      h0 = m_halt;
      for (int k = 0; k < WB; k++) begin
        if (wb_valid[k]) begin
          idx = find(int'(wb_id[k*DB +: DB]));
          if (idx >= 0) begin
            e = mq[idx]; e.rdy = 1; e.val = wb_value[k*32 +: 32]; mq[idx] = e;
          end
        end
      end
      if (e0) void'(mq.pop_front());
      if (e1) void'(mq.pop_front());
      if (e0 && t0 == 2 && v0 != p0) begin
        m_flush = 1; m_flush_pc = v0;
      end
      if (e0 && t0 == 3) m_halt = 1;
      if (alloc_valid && n < DEPTH && !h0) begin
        e.id = m_tail; e.rdy = alloc_ready; e.typ = alloc_type; e.rd = alloc_rd;
        e.val = alloc_value; e.pred = alloc_pred_pc;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'd0, 5'd5,  1'b1, 32'h11,       32'h0,  1'b1, 5'd5,  1'b0, 1'b0};
    vt[1] = '{2'd0, 5'd31, 1'b1, 32'hFFFFFFFF, 32'h0,  1'b1, 5'd31, 1'b0, 1'b0};
    vt[2] = '{2'd1, 5'd7,  1'b1, 32'h33,       32'h0,  1'b1, 5'd0,  1'b1, 1'b0};
    vt[3] = '{2'd2, 5'd3,  1'b1, 32'h40,       32'h40, 1'b1, 5'd0,  1'b0, 1'b0};
    vt[4] = '{2'd2, 5'd3,  1'b1, 32'h44,       32'h40, 1'b1, 5'd0,  1'b0, 1'b1};
    vt[5] = '{2'd0, 5'd9,  1'b0, 32'h55,       32'h0,  1'b0, 5'd0,  1'b0, 1'b0};

    idle();
    rst_in = 1'b0;
    #12;
    chk_reset_outputs("rst");
    tick();
    rst_in = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      alloc(vt[i].typ, vt[i].rd, vt[i].rdy, vt[i].val, vt[i].pred);
      tick();
      idle();
      #1;
      chk($sformatf("vec%0d_cv0", i), commit_valid[0], vt[i].ecv);
      if (vt[i].ecv) begin
        chk($sformatf("vec%0d_rd", i), commit_rd[4:0], vt[i].erd);
        chk($sformatf("vec%0d_value", i), commit_value[31:0], vt[i].val);
      end
      chk($sformatf("vec%0d_store", i), store_commit, vt[i].est);
      tick();
      chk($sformatf("vec%0d_flush", i), flush, vt[i].efl);
    end

    // Fill to full, then one more alloc that must be dropped.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(2'd0, 5'(i), 1'b0, 0, 0);
      tick();
    end
    idle(); #1;
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    chk("fill_alloc_id", alloc_id, 0);
    alloc(2'd0, 5'd1, 1'b1, 32'h99, 0);
    tick();
    idle(); #1;
    chk("over_count", count, 16);
    chk("over_alloc_id", alloc_id, 0);

    // Dual commit of two RG entries.
    do_reset();
    alloc(2'd0, 5'd5, 1'b0, 0, 0);
    tick();
    alloc(2'd0, 5'd6, 1'b1, 32'h22, 0);
    wb_valid = 2'b01; wb_id = '0; wb_value = {32'd0, 32'h11};
    tick();
    idle(); #1;
    chk("dual_cv", commit_valid, 2'b11);
    chk("dual_rd", commit_rd, {5'd6, 5'd5});
    chk("dual_value", commit_value, {32'h22, 32'h11});
    tick();
    chk("dual_count", count, 0);
    chk("dual_head", head_id, 2);

    // Mispredicted branch followed by a younger entry.
    do_reset();
    alloc(2'd2, 5'd0, 1'b0, 0, 32'h100);
    tick();
    alloc(2'd0, 5'd1, 1'b0, 0, 0);
    wb_valid = 2'b01; wb_id = '0; wb_value = {32'd0, 32'h200};
    tick();
    idle(); #1;
    chk("br_cv", commit_valid, 2'b01);
    chk("br_flush_pre", flush, 0);
    tick();
    chk("br_flush", flush, 1);
    chk("br_flush_pc", flush_pc, 32'h200);
    chk("br_flush_cv", commit_valid, 0);
    chk("br_flush_count", count, 1);
    tick();
    chk("br_after_flush", flush, 0);
    chk("br_after_count", count, 0);
    chk("br_after_empty", empty, 1);
    chk("br_after_alloc_id", alloc_id, 0);

    // Two ports hitting the same id: higher port wins, bypass then stored.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(2'd0, 5'(i), 1'b0, 0, 0);
      tick();
    end
    idle();
    wb_valid = 2'b11; wb_id = {4'd3, 4'd3}; wb_value = {32'hB, 32'hA};
    q_id = {4'd2, 4'd3};
    #1;
    chk("byp_q_ready", q_ready, 2'b01);
    chk("byp_q_value", q_value, {32'd0, 32'hB});
    tick();
    idle();
    q_id = {4'd2, 4'd3};
    #1;
    chk("stored_q_ready", q_ready, 2'b01);
    chk("stored_q_value", q_value[31:0], 32'hB);

    // Two stores retire one per cycle, then EX halts.
    do_reset();
    alloc(2'd1, 5'd0, 1'b0, 0, 0);
    tick();
    alloc(2'd1, 5'd0, 1'b0, 0, 0);
    tick();
    idle();
    wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_value = {32'h2, 32'h1};
    tick();
    idle(); #1;
    chk("st1_cv", commit_valid, 2'b01);
    chk("st1_store", store_commit, 1);
    tick();
    chk("st2_cv", commit_valid, 2'b01);
    chk("st2_store", store_commit, 1);
    chk("st2_count", count, 1);
    tick();
    chk("st_done_count", count, 0);
    chk("st_done_store", store_commit, 0);
    alloc(2'd3, 5'd0, 1'b1, 0, 0);
    tick();
    idle(); #1;
    chk("ex_cv", commit_valid, 2'b01);
    chk("ex_halt_pre", halt, 0);
    tick();
    chk("ex_halt", halt, 1);
    alloc(2'd0, 5'd3, 1'b1, 32'h7, 0);
    #1;
    chk("halt_cv", commit_valid, 0);
    tick();
    idle(); #1;
    chk("halt_count", count, 0);
    chk("halt_alloc_id", alloc_id, 3);
    chk("halt_sticky", halt, 1);
    chk("halt_cv2", commit_valid, 0);

    // Asynchronous reset in the middle of a cycle with 5 busy entries.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc(2'd0, 5'(i), 1'b0, 0, 0);
      tick();
    end
    idle();
    wb_valid = 2'b01; wb_id = {4'd0, 4'd1}; wb_value = {32'd0, 32'h5};
    tick();
    idle();
    q_id = {4'd1, 4'd1};
    #1;
    chk("pre_async_count", count, 5);
    chk("pre_async_q_ready", q_ready, 2'b11);
    #1;
    rst_in = 1'b0;
    #1;
    chk_reset_outputs("async");
    tick();
    rst_in = 1'b1;
    model_reset();

    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 400; c++) rand_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
